// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
//   Bundles the load handshake and serial output of piso_serializer.
//   master : the producer/consumer side (drives par_in/load_valid, observes the rest)
//   slave  : the serializer itself
// Signals:
//   par_in     [WIDTH-1:0]  parallel word to serialize
//   load_valid              par_in holds a valid word
//   load_ready              serializer can take a word this cycle
//   ser_out                 serial data bit, MSB first
//   ser_valid               ser_out carries a frame bit this cycle
//   done                    pulse coincident with the last frame bit
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] par_in;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             done;

  modport master (
    output par_in, load_valid,
    input  load_ready, ser_out, ser_valid, done
  );

  modport slave (
    input  par_in, load_valid,
    output load_ready, ser_out, ser_valid, done
  );
endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out stage. A WIDTH-bit word is taken on a
//   load_valid/load_ready handshake and emitted MSB-first, one bit per clk,
//   starting the cycle after the accept edge. Words can be chained with no
//   idle gap: the next word is accepted on the edge that ends the current one.
//
// Parameters:
//   WIDTH  parallel word width, 2..32
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-low
//   bus   piso_serializer_if.slave (par_in, load_valid, load_ready,
//         ser_out, ser_valid, done)
//
// Optional feature (macro PARITY_EN):
//   When defined, an even-parity bit (^word) is appended after the data bits,
//   making the frame WIDTH+1 bits; done and load_ready move to that cycle.
//   When undefined, there is no parity state or parity register.
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  piso_serializer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
`ifdef PARITY_EN
  logic             par;
`endif

  logic             last_bit;
  logic             load_ready;
  logic             take;
  logic             ser_bit;

  // The final frame bit is the last data bit, or the parity bit when enabled.
  // The serializer is free again in that same cycle so chained words abut.
`ifdef PARITY_EN
  assign last_bit = (state == PARITY);
`else
  assign last_bit = (state == SHIFT) && (cnt == '0);
`endif

  assign load_ready = (state == IDLE) || last_bit;
  assign take       = bus.load_valid && load_ready;

  // Everything here depends only on registered state, so no input reaches
  // an output combinationally.
  always_comb begin
    ser_bit = 1'b0;
    case (state)
      SHIFT:   ser_bit = shreg[WIDTH-1];
`ifdef PARITY_EN
      PARITY:  ser_bit = par;
`endif
      default: ser_bit = 1'b0;
    endcase
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_valid  = (state != IDLE);
  assign bus.ser_out    = ser_bit;
  assign bus.done       = last_bit;

  // Frame control. An accepted word always wins, which is what restarts SHIFT
  // straight out of the final bit of the previous frame. Otherwise SHIFT walks
  // the word out MSB-first until cnt runs down, then moves on to parity or idle.
  // Reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef PARITY_EN
      par   <= 1'b0;
`endif
    end else if (take) begin
      state <= SHIFT;
      shreg <= bus.par_in;
      cnt   <= CNT_W'(WIDTH - 1);
`ifdef PARITY_EN
      par   <= ^bus.par_in;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
          end else begin
`ifdef PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef PARITY_EN
        PARITY:  state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Self-checking bench for piso_serializer. Expected frame bits are pushed to
//   a queue when a word is driven and popped as the serializer emits them.
//   Default build: WIDTH=4, no parity. With PARITY_EN defined: WIDTH=8.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PARITY_EN
  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = WIDTH;
`endif

  typedef struct packed {
    logic ser;
    logic last;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];

  piso_serializer_if #(.WIDTH(WIDTH)) bus_if ();

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // 10-unit clock; stimulus changes #1 after posedge, sampling on negedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of one frame: data bits MSB first, then even parity when enabled.
  function automatic void push_word(input logic [WIDTH-1:0] w);
    exp_t e;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      e.ser = w[i];
`ifdef PARITY_EN
      e.last = 1'b0;
`else
      e.last = (i == 0);
`endif
      exp_q.push_back(e);
    end
`ifdef PARITY_EN
    e.ser  = ^w;
    e.last = 1'b1;
    exp_q.push_back(e);
`endif
  endfunction

  // Held reset, then idle after release.
  task automatic test_reset();
    rst = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.par_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus_if.load_ready, bus_if.ser_valid, bus_if.ser_out, bus_if.done} !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got rdy/val/out/done=%b want 1000",
               {bus_if.load_ready, bus_if.ser_valid, bus_if.ser_out, bus_if.done});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({bus_if.load_ready, bus_if.ser_valid, bus_if.ser_out, bus_if.done} !== 4'b1000) begin
        tests_failed++;
        $display("[TB] FAIL reset_idle cycle %0d got rdy/val/out/done=%b want 1000", c,
                 {bus_if.load_ready, bus_if.ser_valid, bus_if.ser_out, bus_if.done});
      end
    end
    @(posedge clk); #1;
  endtask

  // One word, then verify the serializer returns to idle.
  task automatic test_single_word(input logic [WIDTH-1:0] word, input string name);
    exp_t e;
    bus_if.par_in = word;
    bus_if.load_valid = 1'b1;
    push_word(word);
    @(posedge clk); #1;
    bus_if.load_valid = 1'b0;
    bus_if.par_in = '0;
    for (int c = 1; c <= FRAME_LEN; c++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL %s cycle %0d: scoreboard empty", name, c);
      end else begin
        e = exp_q.pop_front();
        if ({bus_if.ser_valid, bus_if.ser_out, bus_if.done, bus_if.load_ready} !==
            {1'b1, e.ser, e.last, e.last}) begin
          tests_failed++;
          $display("[TB] FAIL %s cycle %0d got val/out/done/rdy=%b want %b", name, c,
                   {bus_if.ser_valid, bus_if.ser_out, bus_if.done, bus_if.load_ready},
                   {1'b1, e.ser, e.last, e.last});
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests_run++;
    if ({bus_if.ser_valid, bus_if.load_ready, bus_if.ser_out, exp_q.size() == 0} !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL %s_idle got val/rdy/out/qempty=%b want 0101", name,
               {bus_if.ser_valid, bus_if.load_ready, bus_if.ser_out, exp_q.size() == 0});
    end
    @(posedge clk); #1;
  endtask

  // Two words with load_valid held: contiguous frames, done on each last bit.
  // With busy_load set, the second word is only presented during cycle 2 of the
  // first frame, while the serializer is busy.
  task automatic test_two_words(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                                input bit busy_load, input string name);
    exp_t e;
    bus_if.par_in = w0;
    bus_if.load_valid = 1'b1;
    push_word(w0);
    @(posedge clk); #1;
    if (busy_load) begin
      bus_if.load_valid = 1'b0;
      bus_if.par_in = '0;
    end else begin
      bus_if.par_in = w1;
      push_word(w1);
    end
    for (int c = 1; c <= 2 * FRAME_LEN; c++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL %s cycle %0d: scoreboard empty", name, c);
      end else begin
        e = exp_q.pop_front();
        if ({bus_if.ser_valid, bus_if.ser_out, bus_if.done} !== {1'b1, e.ser, e.last}) begin
          tests_failed++;
          $display("[TB] FAIL %s cycle %0d got val/out/done=%b want %b", name, c,
                   {bus_if.ser_valid, bus_if.ser_out, bus_if.done}, {1'b1, e.ser, e.last});
        end
      end
      @(posedge clk); #1;
      if (busy_load && c == 1) begin
        bus_if.par_in = w1;
        bus_if.load_valid = 1'b1;
        push_word(w1);
      end
      if (c == FRAME_LEN) begin
        bus_if.load_valid = 1'b0;
        bus_if.par_in = '0;
      end
    end
    @(negedge clk);
    tests_run++;
    if ({bus_if.ser_valid, bus_if.load_ready, exp_q.size() == 0} !== 3'b011) begin
      tests_failed++;
      $display("[TB] FAIL %s_idle got val/rdy/qempty=%b want 011", name,
               {bus_if.ser_valid, bus_if.load_ready, exp_q.size() == 0});
    end
    @(posedge clk); #1;
  endtask

  // Reset asserted during the second bit aborts the rest of the frame.
  task automatic test_mid_frame_reset(input logic [WIDTH-1:0] word);
    exp_t e;
    bus_if.par_in = word;
    bus_if.load_valid = 1'b1;
    push_word(word);
    @(posedge clk); #1;
    bus_if.load_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL mid_reset cycle %0d: scoreboard empty", c);
      end else begin
        e = exp_q.pop_front();
        if ({bus_if.ser_valid, bus_if.ser_out} !== {1'b1, e.ser}) begin
          tests_failed++;
          $display("[TB] FAIL mid_reset cycle %0d got val/out=%b want %b", c,
                   {bus_if.ser_valid, bus_if.ser_out}, {1'b1, e.ser});
        end
      end
      @(posedge clk); #1;
      if (c == 1) rst = 1'b0;
    end
    exp_q.delete();
    @(negedge clk);
    tests_run++;
    if ({bus_if.ser_valid, bus_if.ser_out, bus_if.load_ready, bus_if.done} !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_abort got val/out/rdy/done=%b want 0010",
               {bus_if.ser_valid, bus_if.ser_out, bus_if.load_ready, bus_if.done});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      tests_run++;
      if ({bus_if.ser_valid, bus_if.ser_out, bus_if.load_ready} !== 3'b001) begin
        tests_failed++;
        $display("[TB] FAIL mid_reset_after cycle %0d got val/out/rdy=%b want 001", c,
                 {bus_if.ser_valid, bus_if.ser_out, bus_if.load_ready});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.par_in = '0;
    @(posedge clk); #1;
    test_reset();
`ifdef PARITY_EN
    test_single_word(8'hA5, "parity_a5");
    test_single_word(8'h01, "parity_01");
    test_single_word(8'hFF, "parity_ff");
`else
    test_single_word(4'b1011, "single_1011");
    test_two_words(4'b1011, 4'b0110, 1'b0, "back_to_back");
    test_two_words(4'b1000, 4'b1111, 1'b1, "busy_load");
    test_mid_frame_reset(4'b1101);
    test_single_word(4'b0001, "single_0001");
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
